// File: rtl/lcd_rtc_display.sv
// lcd_rtc_display: BCD real-time clock with run-time 12/24-hour rendering
// on an HD44780 character LCD driven over its 4-bit bus.
module lcd_rtc_display #(
    parameter int CLK_HZ       = 12000000,
    parameter int EN_CYCLES    = 800,
    parameter int PWRUP_CYCLES = 60000,
    parameter int CLEAR_CYCLES = 60000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode12,
    input  logic       set_hour,
    input  logic       set_min,
    output logic       tick,
    output logic       rs,
    output logic       en,
    output logic [3:0] data
);
    localparam int PW = $clog2(CLK_HZ + 1);
    localparam int WAIT_MAX = PWRUP_CYCLES > CLEAR_CYCLES ? PWRUP_CYCLES : CLEAR_CYCLES;
    localparam int SEQ_MAX = WAIT_MAX > 2 * EN_CYCLES ? WAIT_MAX : 2 * EN_CYCLES;
    localparam int CW = $clog2(SEQ_MAX + 1);
    localparam logic [3:0] INIT_TAB [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                             4'h0, 4'hC, 4'h0, 4'h6, 4'h0, 4'h1};

    typedef enum logic [2:0] {PWRUP, INIT, CLRWAIT, ADDR, CHARS} state_t;

    logic [PW-1:0] pcnt;
    logic [7:0]    hr, mn, sc;
    logic [7:0]    sh, sm, ss;
    logic          s12;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [4:0]    idx, ni, hb, hd;
    logic [7:0]    frame [11];
    logic [3:0]    init_nib, char_nib;
    logic          wait_done, slot_end, enter_addr;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        return v == top ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    // A set pulse overrides the prescaler terminal, so no tick and no double advance.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pcnt <= '0;
            tick <= 1'b0;
            hr   <= '0;
            mn   <= '0;
            sc   <= '0;
        end else if (set_hour || set_min) begin
            pcnt <= '0;
            tick <= 1'b0;
            sc   <= '0;
            if (set_min) mn <= bcd_inc(mn, 8'h59);
            if (set_hour) hr <= bcd_inc(hr, 8'h23);
        end else if (pcnt == PW'(CLK_HZ - 1)) begin
            pcnt <= '0;
            tick <= 1'b1;
            sc   <= bcd_inc(sc, 8'h59);
            if (sc == 8'h59) mn <= bcd_inc(mn, 8'h59);
            if (sc == 8'h59 && mn == 8'h59) hr <= bcd_inc(hr, 8'h23);
        end else begin
            pcnt <= pcnt + 1'b1;
            tick <= 1'b0;
        end

    always_comb begin
        ni         = idx + 5'd1;
        hb         = 5'(sh[7:4]) * 5'd10 + 5'(sh[3:0]);
        hd         = hb == 5'd0 ? 5'd12 : hb > 5'd12 ? hb - 5'd12 : hb;
        frame[0]   = s12 ? (hd >= 5'd10 ? 8'h31 : 8'h30) : {4'h3, sh[7:4]};
        frame[1]   = s12 ? {4'h3, hd >= 5'd10 ? 4'(hd - 5'd10) : hd[3:0]} : {4'h3, sh[3:0]};
        frame[2]   = 8'h3A;
        frame[3]   = {4'h3, sm[7:4]};
        frame[4]   = {4'h3, sm[3:0]};
        frame[5]   = 8'h3A;
        frame[6]   = {4'h3, ss[7:4]};
        frame[7]   = {4'h3, ss[3:0]};
        frame[8]   = 8'h20;
        frame[9]   = s12 ? (hb >= 5'd12 ? 8'h50 : 8'h41) : 8'h20;
        frame[10]  = s12 ? 8'h4D : 8'h20;
        init_nib   = INIT_TAB[ni[3:0]];
        char_nib   = ni[0] ? frame[ni[4:1]][3:0] : frame[ni[4:1]][7:4];
        wait_done  = cnt == CW'((state == PWRUP ? PWRUP_CYCLES : CLEAR_CYCLES) - 1);
        slot_end   = cnt == CW'(2 * EN_CYCLES - 1);
        enter_addr = (state == CLRWAIT && wait_done) || (state == CHARS && slot_end && idx == 5'd21);
    end

    // The frame is rendered from a snapshot so one frame never mixes two times or modes.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sh  <= '0;
            sm  <= '0;
            ss  <= '0;
            s12 <= 1'b0;
        end else if (enter_addr) begin
            sh  <= hr;
            sm  <= mn;
            ss  <= sc;
            s12 <= mode12;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= PWRUP;
            cnt   <= '0;
            idx   <= '0;
            rs    <= 1'b0;
            en    <= 1'b0;
            data  <= '0;
        end else if (state == PWRUP || state == CLRWAIT) begin
            if (wait_done) begin
                cnt   <= '0;
                idx   <= '0;
                en    <= 1'b1;
                rs    <= 1'b0;
                state <= state == PWRUP ? INIT : ADDR;
                data  <= state == PWRUP ? 4'h3 : 4'h8;
            end else
                cnt <= cnt + 1'b1;
        end else begin
            if (cnt == CW'(EN_CYCLES - 1)) en <= 1'b0;
            if (!slot_end)
                cnt <= cnt + 1'b1;
            else begin
                cnt <= '0;
                idx <= ni;
                en  <= 1'b1;
                case (state)
                    INIT:
                        if (idx == 5'd11) begin
                            state <= CLRWAIT;
                            en    <= 1'b0;
                        end else
                            data <= init_nib;
                    ADDR:
                        if (idx == 5'd1) begin
                            state <= CHARS;
                            idx   <= '0;
                            rs    <= 1'b1;
                            data  <= frame[0][7:4];
                        end else
                            data <= 4'h0;
                    default:
                        if (idx == 5'd21) begin
                            state <= ADDR;
                            idx   <= '0;
                            rs    <= 1'b0;
                            data  <= 4'h8;
                        end else
                            data <= char_nib;
                endcase
            end
        end
endmodule

// File: tb/tb_lcd_rtc_display.sv
// tb_lcd_rtc_display: randomized stimulus against a seconds-of-day reference
// model; expected LCD nibbles are queued and checked by an independent monitor.
module tb_lcd_rtc_display;
    localparam int CLK_HZ = 10, EN = 2, PWR = 20, CLR = 8;
    localparam int FIRST_ADDR = PWR + 12 * 2 * EN + CLR;
    localparam int FRAME = 48 * EN;

    typedef struct {
        logic       rs;
        logic [3:0] d;
        int         gap;
    } nib_t;

    logic clk = 0, rst_n = 1, mode12 = 0, set_hour = 0, set_min = 0;
    logic tick, rs, en;
    logic [3:0] data;

    int errs = 0, checks = 0;
    int t = 0, pre = 0, ecyc = 0;
    logic exp_tick = 0;
    nib_t q[$];
    nib_t e;
    int init_nibs[12] = '{3, 3, 3, 2, 2, 8, 0, 12, 0, 6, 0, 1};
    int hi = 0, gap = 0;
    logic prev_en = 0, l_rs = 0;
    logic [3:0] l_d = 0;

    lcd_rtc_display #(.CLK_HZ(CLK_HZ), .EN_CYCLES(EN), .PWRUP_CYCLES(PWR), .CLEAR_CYCLES(CLR)) dut (
        .clk(clk), .rst_n(rst_n), .mode12(mode12), .set_hour(set_hour), .set_min(set_min),
        .tick(tick), .rs(rs), .en(en), .data(data)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(logic r, int d, int g);
        q.push_back('{r, 4'(d), g});
    endtask

    task automatic push_frame(int g);
        int h, m, s, dh;
        logic [7:0] c[11];
        h  = t / 3600;
        m  = (t / 60) % 60;
        s  = t % 60;
        dh = mode12 ? (h % 12 == 0 ? 12 : h % 12) : h;
        c[0]  = 8'(48 + dh / 10);
        c[1]  = 8'(48 + dh % 10);
        c[2]  = 8'h3A;
        c[3]  = 8'(48 + m / 10);
        c[4]  = 8'(48 + m % 10);
        c[5]  = 8'h3A;
        c[6]  = 8'(48 + s / 10);
        c[7]  = 8'(48 + s % 10);
        c[8]  = 8'h20;
        c[9]  = mode12 ? (h >= 12 ? 8'h50 : 8'h41) : 8'h20;
        c[10] = mode12 ? 8'h4D : 8'h20;
        push(0, 8, g);
        push(0, 0, 2 * EN - EN);
        for (int i = 0; i < 11; i++) begin
            push(1, int'(c[i][7:4]), EN);
            push(1, int'(c[i][3:0]), EN);
        end
    endtask

    // Reference model: time as seconds of day, frames start at fixed offsets from reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t = 0;
            pre = 0;
            ecyc = 0;
            exp_tick = 0;
            q.delete();
            for (int i = 0; i < 12; i++) push(0, init_nibs[i], i == 0 ? PWR : EN);
        end else begin
            int h, m;
            ecyc++;
            if (ecyc >= FIRST_ADDR && (ecyc - FIRST_ADDR) % FRAME == 0)
                push_frame(ecyc == FIRST_ADDR ? EN + CLR : EN);
            if (set_hour || set_min) begin
                h = t / 3600;
                m = (t / 60) % 60;
                if (set_min) m = (m + 1) % 60;
                if (set_hour) h = (h + 1) % 24;
                t = h * 3600 + m * 60;
                pre = 0;
                exp_tick = 0;
            end else if (pre == CLK_HZ - 1) begin
                pre = 0;
                t = (t + 1) % 86400;
                exp_tick = 1;
            end else begin
                pre++;
                exp_tick = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en = 0;
            gap = 0;
            hi = 0;
            l_rs = 0;
            l_d = 0;
        end else begin
            chk("tick", tick, exp_tick);
            if (en && !prev_en) begin
                if (q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL nib_unexpected: got rs=%0d data=%0d expected no strobe at %0t", rs, data, $time);
                end else begin
                    e = q.pop_front();
                    chk("nib_rs", rs, e.rs);
                    chk("nib_data", data, e.d);
                    chk("nib_gap", gap, e.gap);
                end
                l_rs = rs;
                l_d = data;
                hi = 1;
                gap = 0;
            end else begin
                chk("hold_rs", rs, l_rs);
                chk("hold_data", data, l_d);
                if (en) hi++;
                else begin
                    if (prev_en) chk("en_high", hi, EN);
                    gap++;
                end
            end
            prev_en = en;
        end
    end

    task automatic pulse(logic h, logic m);
        set_hour = h;
        set_min = m;
        @(posedge clk); #2;
        set_hour = 0;
        set_min = 0;
        @(posedge clk); #2;
    endtask

    task automatic goto_hm(int h, int m);
        for (int i = 0; i < 24 && t / 3600 != h; i++) pulse(1, 0);
        for (int i = 0; i < 60 && (t / 60) % 60 != m; i++) pulse(0, 1);
    endtask

    task automatic wait_sec(int s);
        for (int i = 0; i < 1000 && t % 60 != s; i++) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic collide();
        for (int i = 0; i < CLK_HZ + 2 && pre != CLK_HZ - 1; i++) begin
            @(posedge clk); #2;
        end
        set_hour = 1;
        @(posedge clk); #2;
        set_hour = 0;
        @(negedge clk);
        chk("collide_tick", tick, 0);
        @(posedge clk); #2;
    endtask

    initial begin
        logic seen;
        #1 rst_n = 0;
        #1;
        chk("reset_tick", tick, 0);
        chk("reset_en", en, 0);
        chk("reset_rs", rs, 0);
        chk("reset_data", data, 0);
        @(posedge clk); #2;
        rst_n = 1;
        repeat (300) @(posedge clk);
        #2;
        repeat (1500) begin
            set_hour = $urandom_range(15) == 0;
            set_min = $urandom_range(15) == 0;
            if ($urandom_range(63) == 0) mode12 = ~mode12;
            @(posedge clk); #2;
        end
        set_hour = 0;
        set_min = 0;
        mode12 = 0;
        goto_hm(23, 59);
        wait_sec(58);
        repeat (300) @(posedge clk);
        #2;
        mode12 = 1;
        repeat (200) @(posedge clk);
        #2;
        goto_hm(12, 0);
        repeat (200) @(posedge clk);
        #2;
        goto_hm(13, 0);
        repeat (200) @(posedge clk);
        #2;
        mode12 = 0;
        goto_hm(5, 59);
        wait_sec(37);
        pulse(0, 1);
        repeat (200) @(posedge clk);
        #2;
        collide();
        collide();
        repeat (100) @(posedge clk);
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk); #1;
            seen = en && rs;
        end
        chk("midframe_found", seen, 1);
        rst_n = 0;
        #1;
        chk("midreset_en", en, 0);
        chk("midreset_rs", rs, 0);
        chk("midreset_data", data, 0);
        chk("midreset_tick", tick, 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1;
        repeat (300) @(posedge clk);
        #2;
        chk("queue_drained", q.size() <= 26, 1);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
